// File: rtl/serial_add_ctrl.sv
// Bit-serial add/subtract controller that time-shares one external full adder, LSB first.
// Handshake: a transfer happens on a rising edge where valid and ready are both high; the producer holds valid until then.
module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             op_sub,
    input  logic             cin,
    output logic             fa_a,
    output logic             fa_b,
    output logic             fa_c,
    input  logic             fa_sum,
    input  logic             fa_carry,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_sum,
    output logic             res_cout,
    output logic             res_ovf,
    output logic             busy,
    output logic [1:0]       dbg_state
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] res_sh_q, res_sh_d;
    logic [WIDTH-1:0] res_sum_q, res_sum_d;
    logic             carry_q, carry_d;
    logic             cmsb_q, cmsb_d;
    logic             res_cout_q, res_cout_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             run;

    always_comb begin
        state_d    = state_q;
        a_sh_d     = a_sh_q;
        b_sh_d     = b_sh_q;
        res_sh_d   = res_sh_q;
        res_sum_d  = res_sum_q;
        carry_d    = carry_q;
        cmsb_d     = cmsb_q;
        res_cout_d = res_cout_q;
        cnt_d      = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (start_valid) begin
                    // Subtraction is a + ~b + 1, so the inversion and the +1 happen at capture.
                    a_sh_d  = op_a;
                    b_sh_d  = op_sub ? ~op_b : op_b;
                    carry_d = op_sub ? 1'b1 : cin;
                    cnt_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                res_sh_d = WIDTH'({fa_sum, res_sh_q} >> 1);
                a_sh_d   = a_sh_q >> 1;
                b_sh_d   = b_sh_q >> 1;
                carry_d  = fa_carry;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == LAST_BIT) begin
                    // Published results live in their own registers so they survive the next RUN.
                    res_sum_d  = res_sh_d;
                    cmsb_d     = carry_q;
                    res_cout_d = fa_carry;
                    state_d    = S_DONE;
                end
            end
            S_DONE: begin
                if (res_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            a_sh_q     <= '0;
            b_sh_q     <= '0;
            res_sh_q   <= '0;
            res_sum_q  <= '0;
            carry_q    <= 1'b0;
            cmsb_q     <= 1'b0;
            res_cout_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            a_sh_q     <= a_sh_d;
            b_sh_q     <= b_sh_d;
            res_sh_q   <= res_sh_d;
            res_sum_q  <= res_sum_d;
            carry_q    <= carry_d;
            cmsb_q     <= cmsb_d;
            res_cout_q <= res_cout_d;
            cnt_q      <= cnt_d;
        end
    end

    assign run         = (state_q == S_RUN);
    assign start_ready = (state_q == S_IDLE);
    assign res_valid   = (state_q == S_DONE);
    assign busy        = run || res_valid;
    assign dbg_state   = state_q;
    assign fa_a        = run & a_sh_q[0];
    assign fa_b        = run & b_sh_q[0];
    assign fa_c        = run & carry_q;
    assign res_sum     = res_sum_q;
    assign res_cout    = res_cout_q;
    assign res_ovf     = cmsb_q ^ res_cout_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Bench for serial_add_ctrl: an 8-bit instance under directed and random traffic and a 3-bit instance
// run exhaustively, both checked every cycle against an arithmetic model of the operation.
module tb_serial_add_ctrl;

  localparam int W8 = 8;
  localparam int W3 = 3;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        sub;
    logic        cin;
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
  } op_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  int ecnt = 0;
  always @(posedge clk) ecnt <= ecnt + 1;

  // ---------------- 8-bit DUT ----------------
  logic          rst, start_valid, start_ready, op_sub, cin;
  logic [W8-1:0] op_a, op_b, res_sum;
  logic          fa_a, fa_b, fa_c, fa_sum, fa_carry;
  logic          res_valid, res_ready, res_cout, res_ovf, busy;
  logic [1:0]    dbg_state;
  assign fa_sum   = fa_a ^ fa_b ^ fa_c;
  assign fa_carry = (fa_a & fa_b) | (fa_a & fa_c) | (fa_b & fa_c);

  serial_add_ctrl #(.WIDTH(W8)) dut8 (
    .clk(clk), .rst(rst), .start_valid(start_valid), .start_ready(start_ready),
    .op_a(op_a), .op_b(op_b), .op_sub(op_sub), .cin(cin),
    .fa_a(fa_a), .fa_b(fa_b), .fa_c(fa_c), .fa_sum(fa_sum), .fa_carry(fa_carry),
    .res_valid(res_valid), .res_ready(res_ready), .res_sum(res_sum),
    .res_cout(res_cout), .res_ovf(res_ovf), .busy(busy), .dbg_state(dbg_state)
  );

  // ---------------- 3-bit DUT ----------------
  logic          rst3, start_valid3, start_ready3, op_sub3, cin3;
  logic [W3-1:0] op_a3, op_b3, res_sum3;
  logic          fa_a3, fa_b3, fa_c3, fa_sum3, fa_carry3;
  logic          res_valid3, res_ready3, res_cout3, res_ovf3, busy3;
  logic [1:0]    dbg_state3;
  assign fa_sum3   = fa_a3 ^ fa_b3 ^ fa_c3;
  assign fa_carry3 = (fa_a3 & fa_b3) | (fa_a3 & fa_c3) | (fa_b3 & fa_c3);

  serial_add_ctrl #(.WIDTH(W3)) dut3 (
    .clk(clk), .rst(rst3), .start_valid(start_valid3), .start_ready(start_ready3),
    .op_a(op_a3), .op_b(op_b3), .op_sub(op_sub3), .cin(cin3),
    .fa_a(fa_a3), .fa_b(fa_b3), .fa_c(fa_c3), .fa_sum(fa_sum3), .fa_carry(fa_carry3),
    .res_valid(res_valid3), .res_ready(res_ready3), .res_sum(res_sum3),
    .res_cout(res_cout3), .res_ovf(res_ovf3), .busy(busy3), .dbg_state(dbg_state3)
  );

  // ---------------- checking infrastructure ----------------
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
    end
  endtask

  // Plain two's-complement arithmetic on w-bit operands.
  function automatic op_t ref_op(input int w, input logic [31:0] a, input logic [31:0] b,
                                 input logic sub, input logic c);
    op_t o;
    longint m, ua, ub, sa, sb, r, full;
    m  = longint'(1) << w;
    ua = longint'(a);
    ub = longint'(b);
    sa = (ua >= m / 2) ? ua - m : ua;
    sb = (ub >= m / 2) ? ub - m : ub;
    if (sub) begin
      r      = ua - ub;
      o.cout = (ua >= ub);
      full   = sa - sb;
    end else begin
      r      = ua + ub + longint'(c);
      o.cout = (r >= m);
      full   = sa + sb + longint'(c);
    end
    r     = ((r % m) + m) % m;
    o.sum = 32'(r);
    o.ovf = (full < -(m / 2)) || (full > m / 2 - 1);
    o.a   = a;
    o.b   = b;
    o.sub = sub;
    o.cin = c;
    return o;
  endfunction

  // Adder inputs while bit k is processed: operand bits and the carry out of the low k bits.
  function automatic logic [2:0] fa_exp(input op_t o, input int k, input int w);
    longint m, bp, low, av;
    m   = longint'(1) << k;
    av  = longint'(o.a);
    bp  = o.sub ? ((~longint'(o.b)) & ((longint'(1) << w) - 1)) : longint'(o.b);
    low = (av % m) + (bp % m) + (o.sub ? 64'd1 : longint'(o.cin));
    return {av[k], bp[k], low[k]};
  endfunction

  op_t exp_q[$];
  op_t exp3_q[$];

  // ---------------- compare process ----------------
  bit   have8 = 0, have3 = 0;
  op_t  cur8, last8, cur3, last3;
  int   acc8 = 0, acc3 = 0, k8, k3;
  logic [2:0] fx;

  always @(negedge clk) begin
    if (rst) begin
      chk("rst8_start_ready", start_ready, 1);
      chk("rst8_res_valid", res_valid, 0);
      chk("rst8_busy", busy, 0);
      chk("rst8_fa", {fa_a, fa_b, fa_c}, 0);
      chk("rst8_outputs", {res_sum, res_cout, res_ovf}, 0);
      have8 = 0;
      last8 = '{default: '0};
    end else begin
      k8 = ecnt - acc8;
      chk("valid8", res_valid, have8 && k8 >= W8);
      chk("busy8", busy, have8);
      chk("start_ready8", start_ready, !have8);
      fx = (have8 && k8 < W8) ? fa_exp(cur8, k8, W8) : 3'b000;
      chk("fa8", {fa_a, fa_b, fa_c}, fx);
      if (have8 && k8 >= W8)
        chk("result8", {res_sum, res_cout, res_ovf}, {cur8.sum[W8-1:0], cur8.cout, cur8.ovf});
      else
        chk("held8", {res_sum, res_cout, res_ovf}, {last8.sum[W8-1:0], last8.cout, last8.ovf});
      if (have8 && k8 >= W8 && res_ready) begin
        last8 = cur8;
        have8 = 0;
      end else if (!have8 && start_valid && exp_q.size() > 0) begin
        cur8  = exp_q.pop_front();
        have8 = 1;
        acc8  = ecnt + 1;
      end
    end

    if (rst3) begin
      chk("rst3_idle", {start_ready3, res_valid3, busy3}, 3'b100);
      have3 = 0;
      last3 = '{default: '0};
    end else begin
      k3 = ecnt - acc3;
      chk("valid3", res_valid3, have3 && k3 >= W3);
      chk("start_ready3", start_ready3, !have3);
      fx = (have3 && k3 < W3) ? fa_exp(cur3, k3, W3) : 3'b000;
      chk("fa3", {fa_a3, fa_b3, fa_c3}, fx);
      if (have3 && k3 >= W3)
        chk("result3", {res_sum3, res_cout3, res_ovf3}, {cur3.sum[W3-1:0], cur3.cout, cur3.ovf});
      else
        chk("held3", {res_sum3, res_cout3, res_ovf3}, {last3.sum[W3-1:0], last3.cout, last3.ovf});
      if (have3 && k3 >= W3 && res_ready3) begin
        last3 = cur3;
        have3 = 0;
      end else if (!have3 && start_valid3 && exp3_q.size() > 0) begin
        cur3  = exp3_q.pop_front();
        have3 = 1;
        acc3  = ecnt + 1;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic sub, input logic c,
                     input int hold, input bit poke);
    int t;
    t = 0;
    while (!start_ready && t < 100) begin @(posedge clk); #2; t++; end
    exp_q.push_back(ref_op(W8, 32'(a), 32'(b), sub, c));
    op_a = a; op_b = b; op_sub = sub; cin = c;
    start_valid = 1'b1;
    @(posedge clk); #2;
    start_valid = 1'b0;
    op_a = 8'($urandom); op_b = 8'($urandom); op_sub = 1'($urandom); cin = 1'($urandom);
    t = 0;
    while (!res_valid && t < 40) begin @(posedge clk); #2; t++; end
    if (!res_valid) chk("timeout8", res_valid, 1);
    for (int i = 0; i < hold; i++) begin
      start_valid = poke;
      @(posedge clk); #2;
    end
    start_valid = 1'b0;
    res_ready   = 1'b1;
    @(posedge clk); #2;
    res_ready   = 1'b0;
  endtask

  task automatic op3(input logic [2:0] a, input logic [2:0] b, input logic sub, input logic c,
                     input int hold);
    int t;
    t = 0;
    while (!start_ready3 && t < 100) begin @(posedge clk); #2; t++; end
    exp3_q.push_back(ref_op(W3, 32'(a), 32'(b), sub, c));
    op_a3 = a; op_b3 = b; op_sub3 = sub; cin3 = c;
    start_valid3 = 1'b1;
    @(posedge clk); #2;
    start_valid3 = 1'b0;
    t = 0;
    while (!res_valid3 && t < 20) begin @(posedge clk); #2; t++; end
    if (!res_valid3) chk("timeout3", res_valid3, 1);
    for (int i = 0; i < hold; i++) begin @(posedge clk); #2; end
    res_ready3 = 1'b1;
    @(posedge clk); #2;
    res_ready3 = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  op_t pin;

  initial begin
    rst = 1'b1; start_valid = 1'b0; op_a = '0; op_b = '0; op_sub = 1'b0; cin = 1'b0; res_ready = 1'b0;
    rst3 = 1'b1; start_valid3 = 1'b0; op_a3 = '0; op_b3 = '0; op_sub3 = 1'b0; cin3 = 1'b0; res_ready3 = 1'b0;

    // Hand-computed results that pin the model itself.
    pin = ref_op(8, 32'h00, 32'h00, 0, 0); chk("model_0p0", {pin.sum, pin.cout, pin.ovf}, {32'h00, 2'b00});
    pin = ref_op(8, 32'hFF, 32'h01, 0, 0); chk("model_ffp1", {pin.sum, pin.cout, pin.ovf}, {32'h00, 2'b10});
    pin = ref_op(8, 32'h7F, 32'h01, 0, 0); chk("model_7fp1", {pin.sum, pin.cout, pin.ovf}, {32'h80, 2'b01});
    pin = ref_op(8, 32'h05, 32'h07, 1, 0); chk("model_5m7", {pin.sum, pin.cout, pin.ovf}, {32'hFE, 2'b00});
    pin = ref_op(8, 32'h80, 32'h01, 1, 0); chk("model_80m1", {pin.sum, pin.cout, pin.ovf}, {32'h7F, 2'b11});
    pin = ref_op(8, 32'h12, 32'h34, 0, 0); chk("model_12p34", {pin.sum, pin.cout, pin.ovf}, {32'h46, 2'b00});
    pin = ref_op(3, 32'h3, 32'h1, 0, 0);   chk("model3_3p1", {pin.sum, pin.cout, pin.ovf}, {32'h4, 2'b01});

    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
    rst3 = 1'b0;

    fork
      begin
        op8(8'h00, 8'h00, 0, 0, 0, 0);
        op8(8'hFF, 8'h01, 0, 0, 1, 0);
        op8(8'h7F, 8'h01, 0, 0, 0, 0);
        op8(8'h05, 8'h07, 1, 0, 2, 0);
        op8(8'h80, 8'h01, 1, 0, 0, 0);
        op8(8'hA5, 8'h3C, 0, 1, 5, 1);
        // Abort: reset arrives while bit 3 is in the adder.
        exp_q.push_back(ref_op(W8, 32'h55, 32'h22, 0, 0));
        op_a = 8'h55; op_b = 8'h22; op_sub = 1'b0; cin = 1'b0;
        start_valid = 1'b1;
        @(posedge clk); #2;
        start_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
        @(posedge clk); #2;
        rst = 1'b0;
        repeat (12) @(posedge clk);
        #2;
        op8(8'h12, 8'h34, 0, 0, 0, 0);
        for (int i = 0; i < 40; i++)
          op8(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom),
              $urandom_range(0, 3), 1'($urandom_range(0, 1)));
      end
      begin
        for (int s = 0; s < 2; s++)
          for (int c = 0; c < 2; c++)
            for (int a = 0; a < 8; a++)
              for (int b = 0; b < 8; b++)
                op3(3'(a), 3'(b), 1'(s), 1'(c), $urandom_range(0, 1));
      end
    join

    repeat (3) @(posedge clk);
    #2;
    chk("exp_q_drained", exp_q.size(), 0);
    chk("exp3_q_drained", exp3_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout t=%0t", $time);
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/serial_add_ctrl.md
SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

Interface
REQ-001 SHALL have parameter: WIDTH, default 8, operand/result width in bits (legal 2..32).
REQ-002 SHALL have port: clk  input  1  single clock, all state on rising edge.
REQ-003 SHALL have port: rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port: start_valid  input  1  operation request.
REQ-005 SHALL have port: start_ready  output  1  controller can accept a request.
REQ-006 SHALL have ports: op_a, op_b  input  WIDTH  operands; op_sub  input  1  1=subtract (a-b); cin  input  1  carry-in (add only).
REQ-007 SHALL have ports: fa_a, fa_b, fa_c  output  1 each  drive the shared external full_adder inputs a, b, c.
REQ-008 SHALL have ports: fa_sum, fa_carry  input  1 each  from the shared full_adder outputs sum, carry.
REQ-009 SHALL have port: res_valid  output  1  result available.
REQ-010 SHALL have port: res_ready  input  1  consumer accepts result.
REQ-011 SHALL have ports: res_sum  output  WIDTH; res_cout  output  1; res_ovf  output  1 (signed overflow).
REQ-012 SHALL have port: busy  output  1  high in RUN or DONE.

Function
REQ-013 SHALL implement FSM states IDLE, RUN, DONE; start_ready = (state==IDLE); res_valid = (state==DONE).
REQ-014 IDLE: on edge with start_valid&start_ready, SHALL capture a_sh=op_a, b_sh=(op_sub ? ~op_b : op_b), carry_q=(op_sub ? 1 : cin), bit counter=0, go RUN; start_valid in RUN/DONE SHALL be ignored.
REQ-015 RUN: fa_a=a_sh[0], fa_b=b_sh[0], fa_c=carry_q, combinationally; in IDLE/DONE fa_a=fa_b=fa_c=0.
REQ-016 RUN, each edge: result shift register SHALL shift right with fa_sum entering MSB; a_sh, b_sh shift right; carry_q<=fa_carry; counter increments.
REQ-017 On RUN edge with counter==WIDTH-1, SHALL capture carry_q (carry into MSB) into cmsb_q, go DONE; res_cout=carry_q, res_ovf=cmsb_q^carry_q.
REQ-018 Latency: res_valid SHALL rise exactly WIDTH clock edges after the accepting edge; res_sum bit i = sum bit i of a+b(+cin) mod 2^WIDTH.
REQ-019 Subtract: res_sum=(a-b) mod 2^WIDTH; res_cout=1 means no borrow (a>=b unsigned).
REQ-020 DONE: res_sum, res_cout, res_ovf SHALL hold stable while res_valid&!res_ready; on edge with res_ready, SHALL go IDLE (no same-cycle new accept).
REQ-021 Counter SHALL be ceil(log2(WIDTH))+1 bits wide; no wrap inside RUN.
REQ-022 Outputs res_sum/res_cout/res_ovf SHALL remain at last result while IDLE until the next DONE overwrites them.

Reset
REQ-023 rst high SHALL immediately force IDLE; start_ready=1, res_valid=0, busy=0, fa_*=0, res_sum=0, res_cout=0, res_ovf=0, counter=0, carry_q=0.
REQ-024 rst asserted mid-RUN or in DONE SHALL abort the operation; the pending result SHALL be discarded, never presented.
REQ-025 After rst deasserts, first accept SHALL occur on the first edge with start_valid high.

Verification (WIDTH=8 unless stated)
REQ-026 0x00+0x00, cin=0 -> res_sum=0x00, res_cout=0, res_ovf=0; res_valid rises 8 edges after accept.
REQ-027 0xFF+0x01, cin=0 -> res_sum=0x00, res_cout=1, res_ovf=0; 0x7F+0x01 -> res_sum=0x80, res_cout=0, res_ovf=1.
REQ-028 op_sub: 0x05-0x07 -> res_sum=0xFE, res_cout=0; 0x80-0x01 -> res_sum=0x7F, res_ovf=1.
REQ-029 res_ready held low 5 cycles in DONE -> res_valid and outputs stable; start_valid during this ignored; start_ready=0.
REQ-030 rst pulsed at RUN bit 3 -> IDLE next, res_valid never asserted for aborted op; following 0x12+0x34 -> 0x46.
REQ-031 WIDTH=3 exhaustive: all a, b, cin, op_sub against reference arithmetic, each checked with case-equality (no X/Z).
